gf2_poly_div_12bit: RTL



---
 rtl/gf2_poly_div_12bit_pkg.sv | 12 +
 rtl/gf2_poly_div_12bit_if.sv | 24 ++
 rtl/gf2_poly_div_12bit_deg.sv | 17 +
 rtl/gf2_poly_div_12bit.sv | 86 ++++++++
 4 files changed

// File: rtl/gf2_poly_div_12bit_pkg.sv
// Shared constants for the GF(2)[x] bit-serial divider and its helpers.
package gf2_div_pkg;
    localparam int N   = 12;
    localparam int DW  = 2*N - 1;
    localparam int CW  = $clog2(DW);
    localparam int DGW = $clog2(N);

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;
endpackage

// File: rtl/gf2_poly_div_12bit_if.sv
// Operand/result handshake bundle for the GF(2)[x] divider.
interface gf2_poly_div_12bit_if;
    import gf2_div_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] y;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] q;
    logic [N-2:0]  r;
    logic          err;

    modport slave (
        input  in_valid, y, b, out_ready,
        output in_ready, out_valid, q, r, err
    );

    modport master (
        output in_valid, y, b, out_ready,
        input  in_ready, out_valid, q, r, err
    );
endinterface

// File: rtl/gf2_poly_div_12bit_deg.sv
// Highest-set-bit index of a 12-bit polynomial plus an all-zero flag.
module gf2_deg_12bit
    import gf2_div_pkg::*;
(
    input  logic [N-1:0]   i_b,
    output logic [DGW-1:0] o_deg,
    output logic           o_zero
);
    always_comb begin
        o_deg = '0;
        for (int i = 0; i < N; i++) begin
            if (i_b[i]) o_deg = DGW'(i);
        end
    end

    assign o_zero = ~|i_b;
endmodule

// File: rtl/gf2_poly_div_12bit.sv
// Bit-serial GF(2)[x] long divider: 23-bit dividend by 12-bit divisor.
// state | meaning
// IDLE  | ready for operands
// RUN   | one dividend bit per cycle, DW cycles
// DONE  | result held until consumer accepts
module gf2_poly_div_12bit
    import gf2_div_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    gf2_poly_div_12bit_if.slave  bus
);
    state_t          r_state;
    logic [DW-1:0]   r_d;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_rem;
    logic [DW-1:0]   r_q;
    logic [DGW-1:0]  r_deg;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    logic [DGW-1:0]  w_deg;
    logic            w_zero;
    logic [N-1:0]    w_rem_sh;
    logic            w_hit;

    gf2_deg_12bit u_deg (
        .i_b    (bus.b),
        .o_deg  (w_deg),
        .o_zero (w_zero)
    );

    // Bits of the partial remainder above deg(b) are always zero after reduction.
    assign w_rem_sh = {r_rem[N-2:0], r_d[DW-1]};
    assign w_hit    = w_rem_sh[r_deg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_d     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_deg   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_d   <= bus.y;
                        r_b   <= bus.b;
                        r_deg <= w_deg;
                        r_rem <= '0;
                        r_q   <= '0;
                        if (w_zero) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_cnt   <= CW'(DW-1);
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_d   <= {r_d[DW-2:0], 1'b0};
                    r_rem <= w_hit ? (w_rem_sh ^ r_b) : w_rem_sh;
                    r_q   <= {r_q[DW-2:0], w_hit};
                    if (r_cnt == '0) r_state <= DONE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.q         = r_q;
    assign bus.r         = r_rem[N-2:0];
    assign bus.err       = r_err;
endmodule
